// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer.
//   state_e       : sequencer FSM states (idle, running, paused)
//   MODE_ONESHOT  : stop after the first terminal advance
//   MODE_PERIODIC : wrap to zero on terminal advance and keep running
package counter_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between a host and the counter sequencer.
//   master : host side, drives commands and configuration, observes status
//   slave  : sequencer side, consumes commands, drives count/busy/paused/tick/done
interface counter_sequencer_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
);

  logic                  start;
  logic                  stop;
  logic                  mode;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  paused;
  logic                  tick;
  logic                  done;

  modport master (
    output start, stop, mode, limit, prescale,
    input  count, busy, paused, tick, done
  );

  modport slave (
    input  start, stop, mode, limit, prescale,
    output count, busy, paused, tick, done
  );

endinterface

// File: rtl/bin_counter_en.sv
// Width-bit binary up-counter.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears the count
//   en_i    : increment by one this edge
//   clr_i   : synchronous clear, takes priority over en_i
//   count_o : registered count value
module bin_counter_en #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run/stop sequencer around a binary up-counter with prescaler and terminal limit.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of counter_sequencer_if
//           start/stop commands, mode/limit/prescale config (latched on start from idle),
//           count, busy, paused, tick and done status (all registered)
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input logic                clk,
  input logic                reset,
  counter_sequencer_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] PscOne = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [WIDTH-1:0]      limit_q, limit_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  paused_q, paused_d;

  logic                  cnt_en;
  logic                  cnt_clr;
  logic [WIDTH-1:0]      count;
  logic                  advance;
  logic                  terminal;

  assign advance  = (psc_q == prescale_q);
  assign terminal = (count == limit_q);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    limit_d    = limit_q;
    prescale_d = prescale_q;
    psc_d      = psc_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // stop beats start, so a simultaneous pair leaves us idle
        if (bus.start && !bus.stop) begin
          mode_d     = bus.mode;
          limit_d    = bus.limit;
          prescale_d = bus.prescale;
          psc_d      = '0;
          cnt_clr    = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (bus.stop) begin
          // freeze count and prescaler; this edge does not advance
          state_d = StPause;
        end else if (advance) begin
          psc_d = '0;
          if (terminal) begin
            tick_d = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
              cnt_clr = 1'b1;
            end else begin
              // one-shot: count holds at the limit while idle
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end else begin
          psc_d = psc_q + PscOne;
        end
      end
      StPause: begin
        if (bus.stop) begin
          psc_d   = '0;
          cnt_clr = 1'b1;
          state_d = StIdle;
        end else if (bus.start) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d   = (state_d != StIdle);
    paused_d = (state_d == StPause);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      mode_q     <= MODE_ONESHOT;
      limit_q    <= '0;
      prescale_q <= '0;
      psc_q      <= '0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      limit_q    <= limit_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      paused_q   <= paused_d;
    end
  end

  bin_counter_en #(
    .Width (WIDTH)
  ) u_counter (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (cnt_en),
    .clr_i   (cnt_clr),
    .count_o (count)
  );

  assign bus.count  = count;
  assign bus.busy   = busy_q;
  assign bus.paused = paused_q;
  assign bus.tick   = tick_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus randomized commands, checked
// against an elapsed-cycle arithmetic model through an expected-response queue.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  counter_sequencer_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  counter_sequencer #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         paused;
    logic         tick;
    logic         done;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: a run is described by its config and the number of
  // clocks spent running since start; everything else follows arithmetically.
  bit          m_active = 0;
  bit          m_paused = 0;
  bit          m_mode   = 0;
  int unsigned m_l      = 0;
  int unsigned m_p      = 0;
  int unsigned m_cyc    = 0;
  int unsigned m_hold   = 0;

  task automatic chk(input string name, input int unsigned got, input int unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    snap_t       e;
    int unsigned adv;
    bit          tk;
    bit          dn;
    tk = 0;
    dn = 0;
    if (!m_active) begin
      if (bus.start && !bus.stop) begin
        m_active = 1;
        m_paused = 0;
        m_mode   = bus.mode;
        m_l      = 32'(bus.limit);
        m_p      = 32'(bus.prescale);
        m_cyc    = 0;
      end
    end else if (m_paused) begin
      if (bus.stop) begin
        m_active = 0;
        m_paused = 0;
        m_hold   = 0;
      end else if (bus.start) begin
        m_paused = 0;
      end
    end else if (bus.stop) begin
      m_paused = 1;
    end else begin
      m_cyc++;
      if (m_cyc % (m_p + 1) == 0) begin
        adv = m_cyc / (m_p + 1);
        if (adv % (m_l + 1) == 0) begin
          tk = 1;
          if (m_mode == MODE_ONESHOT) begin
            dn       = 1;
            m_active = 0;
            m_hold   = m_l;
          end
        end
      end
    end
    e.tick   = tk;
    e.done   = dn;
    e.busy   = m_active;
    e.paused = m_active && m_paused;
    if (m_active) begin
      adv = m_cyc / (m_p + 1);
      if (m_mode == MODE_PERIODIC) adv = adv % (m_l + 1);
      e.count = W'(adv);
    end else begin
      e.count = W'(m_hold);
    end
    exp_q.push_back(e);
  endtask

  // Model: one expected snapshot per clock edge
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_active = 0;
        m_paused = 0;
        m_cyc    = 0;
        m_hold   = 0;
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Monitor: compare DUT outputs on the falling edge
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",  32'(bus.count),  32'(e.count));
        chk("busy",   32'(bus.busy),   32'(e.busy));
        chk("paused", 32'(bus.paused), 32'(e.paused));
        chk("tick",   32'(bus.tick),   32'(e.tick));
        chk("done",   32'(bus.done),   32'(e.done));
      end
    end
  end

  task automatic drive(input bit s, input bit p, input bit md, input int unsigned lim,
                       input int unsigned psc, input int n);
    bus.start    = s;
    bus.stop     = p;
    bus.mode     = md;
    bus.limit    = W'(lim);
    bus.prescale = PW'(psc);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.start = 0;
    bus.stop  = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic abort_run();
    bus.start = 0;
    bus.stop  = 1;
    repeat (2) @(negedge clk);
    bus.stop = 0;
    idle(2);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_count"},  32'(bus.count),  0);
    chk({tag, "_busy"},   32'(bus.busy),   0);
    chk({tag, "_paused"}, 32'(bus.paused), 0);
    chk({tag, "_tick"},   32'(bus.tick),   0);
    chk({tag, "_done"},   32'(bus.done),   0);
  endtask

  initial begin
    bus.start    = 0;
    bus.stop     = 0;
    bus.mode     = 0;
    bus.limit    = '0;
    bus.prescale = '0;
    #1 reset = 0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1;
    idle(2);

    // periodic L=3 P=0
    drive(1, 0, 1, 3, 0, 1);
    idle(14);
    abort_run();

    // one-shot L=2 P=1
    drive(1, 0, 0, 2, 1, 1);
    idle(10);

    // start+stop together in idle, then stop alone in idle
    drive(1, 1, 1, 4, 0, 3);
    drive(0, 1, 1, 4, 0, 2);
    idle(2);

    // pause at count 4 for 5 cycles, then resume
    drive(1, 0, 1, 9, 0, 1);
    idle(4);
    bus.stop = 1;
    @(negedge clk);
    idle(5);
    bus.start = 1;
    @(negedge clk);
    idle(12);
    abort_run();

    // limit changed mid-run is not picked up until the next start
    drive(1, 0, 1, 5, 0, 1);
    idle(2);
    bus.limit = 8'd1;
    idle(10);
    abort_run();
    drive(1, 0, 1, 1, 0, 1);
    idle(6);
    abort_run();

    // all-ones limit wraps in periodic mode
    drive(1, 0, 1, 255, 0, 1);
    idle(260);
    abort_run();

    // one-shot limit 0 with prescale
    drive(1, 0, 0, 0, 2, 1);
    idle(6);

    // start held high during a run is ignored
    drive(1, 0, 1, 4, 1, 1);
    drive(1, 0, 0, 2, 3, 8);
    abort_run();

    // async reset between edges at count 7
    drive(1, 0, 1, 20, 0, 1);
    idle(7);
    chk("pre_reset_count", 32'(bus.count), 7);
    #2 reset = 0;
    #1 check_quiet("async_reset");
    repeat (2) @(negedge clk);
    check_quiet("held_reset");
    reset = 1;
    idle(1);
    drive(1, 0, 1, 3, 0, 1);
    idle(8);
    abort_run();

    // randomized commands and configuration
    repeat (60) begin
      bus.mode     = 1'($urandom_range(0, 1));
      bus.limit    = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
      bus.prescale = ($urandom_range(0, 7) == 0) ? PW'($urandom) : PW'($urandom_range(0, 3));
      repeat ($urandom_range(10, 60)) begin
        bus.start = ($urandom_range(0, 9) < 2);
        bus.stop  = ($urandom_range(0, 24) == 0);
        @(negedge clk);
      end
    end
    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
